// File: rtl/raggedstone_spinn_aer_if_control.sv
// Control-packet handler for the SpiNNaker <-> AER interface: executes register
// write/read commands and returns read replies as multicast packets.
module raggedstone_spinn_aer_if_control #(
  parameter int unsigned PKT_BITS  = 72,
  parameter logic [31:0] REPLY_KEY = 32'hFFFF_FE00,
  parameter logic [31:0] RKEY_RST  = 32'h0200_0000,
  parameter logic [31:0] RMSK_RST  = 32'hFFFF_F800,
  parameter logic [31:0] MODE_RST  = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PKT_BITS-1:0] cpkt_data,
  input  logic                cpkt_vld,
  output logic                cpkt_rdy,
  output logic [PKT_BITS-1:0] rpkt_data,
  output logic                rpkt_vld,
  input  logic                rpkt_rdy,
  output logic [31:0]         rt_key,
  output logic [31:0]         rt_mask,
  output logic [31:0]         mode,
  output logic [15:0]         err_cnt
);

  typedef enum logic {IDLE, REPLY} state_t;
  state_t state;

  logic [1:0]  op;
  logic [1:0]  idx;
  logic        pl;
  logic [31:0] payload;
  logic [31:0] rd_val;
  logic [31:0] reply_key;
  logic        par;
  logic        is_write;
  logic        is_read;

  assign op      = cpkt_data[13:12];
  assign idx     = cpkt_data[9:8];
  assign pl      = cpkt_data[1];
  assign payload = cpkt_data[71:40];

  assign is_write = (op == 2'b00) && pl && (idx != 2'd3);
  assign is_read  = (op == 2'b01);

  always_comb begin
    rd_val = '0;
    case (idx)
      2'd0:    rd_val = rt_key;
      2'd1:    rd_val = rt_mask;
      2'd2:    rd_val = mode;
      default: rd_val = {16'h0000, err_cnt};
    endcase
  end

  assign reply_key = REPLY_KEY | {30'h0, idx};
  // Header carries a constant single 1 at bit 1, so par = XOR of key and payload gives odd total parity.
  assign par = ^{rd_val, reply_key};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpkt_rdy  <= 1'b0;
      rpkt_vld  <= 1'b0;
      rpkt_data <= '0;
      rt_key    <= RKEY_RST;
      rt_mask   <= RMSK_RST;
      mode      <= MODE_RST;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cpkt_rdy <= 1'b1;
          if (cpkt_vld && cpkt_rdy) begin
            if (is_write) begin
              case (idx)
                2'd0:    rt_key  <= payload;
                2'd1:    rt_mask <= payload;
                default: mode    <= payload;
              endcase
            end else if (is_read) begin
              rpkt_data <= {rd_val, reply_key, 6'b000000, 1'b1, par};
              rpkt_vld  <= 1'b1;
              cpkt_rdy  <= 1'b0;
              state     <= REPLY;
            end else if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 16'd1;
            end
          end
        end
        REPLY: begin
          if (rpkt_rdy) begin
            rpkt_vld <= 1'b0;
            cpkt_rdy <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/raggedstone_spinn_aer_if_control.md
# raggedstone_spinn_aer_if_control

Control-packet handler for the SpiNNaker <-> AER interface. Consumes the control packet stream split off by the packet router. Executes register write and read commands against a small configuration register file, and returns read replies as multicast packets towards SpiNNaker. Its register outputs configure the out_mapper and in_mapper datapaths.

## Interface
Parameters:
- PKT_BITS, 72, SpiNNaker packet width: [7:0] header, [39:8] key, [71:40] payload.
- REPLY_KEY, 32'hFFFF_FE00, key base for reply packets.
- RKEY_RST, 32'h0200_0000, reset value of register 0.
- RMSK_RST, 32'hFFFF_F800, reset value of register 1.
- MODE_RST, 32'h0000_0000, reset value of register 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- cpkt_data, in, PKT_BITS, control packet from router.
- cpkt_vld, in, 1, control packet valid.
- cpkt_rdy, out, 1, control packet accepted.
- rpkt_data, out, PKT_BITS, reply packet towards SpiNNaker.
- rpkt_vld, out, 1, reply valid.
- rpkt_rdy, in, 1, reply accepted.
- rt_key, out, 32, register 0: routing key.
- rt_mask, out, 32, register 1: routing mask.
- mode, out, 32, register 2: mode/control bits.
- err_cnt, out, 16, register 3 (read-only): count of rejected commands.

## Operation
Command decode, applied to the accepted packet:
- op = key[5:4]; idx = key[1:0]; pl = header[1] (payload present).
- op 2'b00 is write: requires pl=1. idx 0..2 loads payload[31:0] into the indexed register. idx 3 is rejected.
- op 2'b01 is read: pl is ignored. The reply carries register idx; register 3 reads as {16'h0, err_cnt}.
- op 2'b10 / 2'b11 are rejected.
- A write with pl=0 is rejected.
- A rejected command increments err_cnt. err_cnt saturates at 16'hFFFF. It is cleared only by rst.

Reply packet:
- key = REPLY_KEY | {30'h0, idx}; payload = register value.
- header = {6'b000000, 1'b1, par}. Bits [7:6]=00 mark a multicast packet.
- par is chosen so the XOR of all PKT_BITS bits is 1 (odd parity).
- Parity of incoming packets is not checked.

FSM states:
- IDLE: cpkt_rdy=1. On cpkt_vld, the packet is accepted.
  - Write or reject: the action completes this edge; stay in IDLE.
  - Read: latch the reply into rpkt_data and go to REPLY.
- REPLY: cpkt_rdy=0, rpkt_vld=1. rpkt_data is held stable. On rpkt_rdy, return to IDLE.

Reset values:
- rt_key=RKEY_RST, rt_mask=RMSK_RST, mode=MODE_RST, err_cnt=0.
- rpkt_vld=0, rpkt_data=0, cpkt_rdy=0 while rst is asserted; state=IDLE.

## Timing
- cpkt_rdy is registered. It is 1 in IDLE from the first clk edge after rst deasserts.
- Handshakes follow the valid/ready rule: transfer when vld&rdy at a rising edge. vld must not depend on rdy.
- Write or reject: the register or err_cnt updates on the accepting edge and is visible the cycle after. Throughput is one command per cycle.
- Read: rpkt_vld rises the cycle after acceptance. The minimum read period is 2 cycles (accept, then reply taken with rpkt_rdy=1). Under back-pressure, rpkt_vld and rpkt_data hold until rpkt_rdy.
- A read reply returns the register value as of the accepting edge. A later write cannot occur before the reply is taken, because cpkt_rdy=0 in REPLY.
- err_cnt saturation: at 16'hFFFF, a further reject leaves it at 16'hFFFF.
- rst mid-REPLY: the pending reply is discarded and rpkt_vld drops asynchronously. All registers return to their reset values.

## Test plan
- Reset: assert rst mid-operation -> all outputs show reset values immediately; cpkt_rdy=1 one cycle after release.
- Write: key 32'h0000_0001, pl=1, payload 32'h1234_5678 -> rt_mask=32'h1234_5678 next cycle; no reply; err_cnt=0.
- Read with back-pressure: key 32'h0000_0010 (op=01, idx=0) after reset; hold rpkt_rdy=0 for 5 cycles.
  - rpkt_vld=1 and stable throughout; cpkt_rdy=0.
  - key=32'hFFFF_FE00, payload=32'h0200_0000, header[7:1]=7'b0000001, total parity odd.
  - Accepted on rpkt_rdy=1; back in IDLE the next cycle.
- Rejects: write with pl=0; write idx 3; op=10 -> err_cnt=3; no registers change. A read of idx 3 then returns payload 32'h0000_0003.
- Back-to-back writes on consecutive cycles to regs 0, 1, 2 -> all three accepted in 3 cycles with the correct values.
- Saturation: force 65 537 rejects (or preload via a bench backdoor to 16'hFFFE, then 3 rejects) -> err_cnt=16'hFFFF.
